// File: rtl/sum_checker.sv
// sum_checker: watches a registered adder, predicts c = a + b (mod 2^WIDTH) LATENCY
// cycles after each accepted operand pair, and reports a verdict after NUM_CHECKS checks.
module sum_checker #(
  parameter  int WIDTH      = 8,
  parameter  int LATENCY    = 1,
  parameter  int NUM_CHECKS = 6,
  localparam int CW         = $clog2(NUM_CHECKS + 1)
) (
  input  logic             i_clk,
  input  logic             i_aresetn,
  input  logic             i_start,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic             o_mismatch,
  output logic [CW-1:0]    o_chk_cnt,
  output logic [CW-1:0]    o_err_cnt,
  output logic [WIDTH-1:0] o_first_exp,
  output logic [WIDTH-1:0] o_first_got
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [CW-1:0]      r_issued;
  logic [CW-1:0]      r_chkCnt;
  logic [CW-1:0]      r_errCnt;
  logic [CW-1:0]      w_nextChk;
  logic [CW-1:0]      w_nextErr;
  logic [LATENCY-1:0] r_pipeVld;
  logic [WIDTH-1:0]   r_pipeExp [LATENCY];
  logic               r_busy;
  logic               r_done;
  logic               r_pass;
  logic               r_mismatch;
  logic [WIDTH-1:0]   r_firstExp;
  logic [WIDTH-1:0]   r_firstGot;
  logic               w_startRun;
  logic               w_accept;
  logic               w_cmpValid;
  logic               w_neq;
  logic [WIDTH-1:0]   w_sum;

  always_comb begin
    w_nextState = r_state;
    w_startRun  = 1'b0;
    w_accept    = 1'b0;
    w_cmpValid  = 1'b0;
    w_neq       = 1'b0;
    w_nextChk   = r_chkCnt;
    w_nextErr   = r_errCnt;
    w_sum       = i_a + i_b;
    case (r_state)
      IDLE, DONE: begin
        if (i_start) begin
          w_startRun  = 1'b1;
          w_nextState = RUN;
          w_nextChk   = '0;
          w_nextErr   = '0;
        end
      end
      RUN: begin
        // Issue is capped at NUM_CHECKS, which keeps both counters in range.
        w_accept   = i_vld && (r_issued < CW'(NUM_CHECKS));
        w_cmpValid = r_pipeVld[LATENCY-1];
        w_neq      = w_cmpValid && (r_pipeExp[LATENCY-1] != i_c);
        if (w_cmpValid) w_nextChk = r_chkCnt + CW'(1);
        if (w_neq) w_nextErr = r_errCnt + CW'(1);
        if (w_nextChk == CW'(NUM_CHECKS)) w_nextState = DONE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state    <= IDLE;
      r_issued   <= '0;
      r_chkCnt   <= '0;
      r_errCnt   <= '0;
      r_pipeVld  <= '0;
      for (int i = 0; i < LATENCY; i++) r_pipeExp[i] <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_mismatch <= 1'b0;
      r_firstExp <= '0;
      r_firstGot <= '0;
    end else begin
      r_state    <= w_nextState;
      r_chkCnt   <= w_nextChk;
      r_errCnt   <= w_nextErr;
      r_busy     <= (w_nextState == RUN);
      r_done     <= (w_nextState == DONE);
      r_pass     <= (w_nextState == DONE) && (w_nextErr == '0);
      r_mismatch <= w_neq;
      if (w_startRun) begin
        r_issued   <= '0;
        r_pipeVld  <= '0;
        r_firstExp <= '0;
        r_firstGot <= '0;
      end else begin
        r_pipeVld[0] <= w_accept;
        r_pipeExp[0] <= w_sum;
        for (int i = 1; i < LATENCY; i++) begin
          r_pipeVld[i] <= r_pipeVld[i-1];
          r_pipeExp[i] <= r_pipeExp[i-1];
        end
        if (w_accept) r_issued <= r_issued + CW'(1);
        if (w_neq && (r_errCnt == '0)) begin
          r_firstExp <= r_pipeExp[LATENCY-1];
          r_firstGot <= i_c;
        end
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_mismatch  = r_mismatch;
  assign o_chk_cnt   = r_chkCnt;
  assign o_err_cnt   = r_errCnt;
  assign o_first_exp = r_firstExp;
  assign o_first_got = r_firstGot;

endmodule
